// File: rtl/alu_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_sequencer_if
//
// Purpose: bundles the command and response handshakes of alu_sequencer.
//
// Signals:
//   cmd_valid / cmd_ready  command handshake (producer -> sequencer)
//   cmd_op[3:0]            ALU opcode, forwarded unchanged to the ALU
//   cmd_a / cmd_b          operands (cmd_a ignored when cmd_acc=1)
//   cmd_acc                use the accumulator as operand A
//   acc_clr                synchronous accumulator clear
//   rsp_valid / rsp_ready  response handshake (sequencer -> consumer)
//   rsp_data               captured ALU result
//   rsp_flags[1:0]         {neg, zero} of the result, only when the macro
//                          ALU_SEQ_FLAGS_EN is defined
//
// Modports:
//   master - the command producer / response consumer
//   slave  - the sequencer itself
// -----------------------------------------------------------------------------
interface alu_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_acc;
  logic             acc_clr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
`ifdef ALU_SEQ_FLAGS_EN
  logic [1:0]       rsp_flags;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, acc_clr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_flags
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, acc_clr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_flags
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, acc_clr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc, acc_clr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
`endif
endinterface

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Purpose: command-side initiator for an external 4-bit combinational ALU.
// Commands arrive over a valid/ready handshake into a DEPTH-entry FIFO. One
// command at a time is issued to the ALU on registered alu_a/alu_b/alu_op
// lines; after one settle cycle the ALU result alu_s is captured and returned
// over a valid/ready response handshake. An accumulator holds the last result
// so chained commands (cmd_acc=1) can use it as operand A.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          alu_sequencer_if.slave (command / response handshakes)
//   alu_a/alu_b  registered operands to the ALU
//   alu_op       registered opcode to the ALU (Op[3] passed through)
//   alu_s        combinational result from the ALU
//   busy         FSM not idle or FIFO not empty
//
// Parameters:
//   WIDTH  datapath width (matches the ALU)
//   DEPTH  command FIFO entries, power of two and at least 2
//
// Optional feature (macro ALU_SEQ_FLAGS_EN): adds bus.rsp_flags = {neg, zero},
// captured together with rsp_data. Without the macro the flag logic is absent.
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_sequencer_if.slave   bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_s,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q,     state_d;
  logic [AW:0]      wr_ptr_q,    wr_ptr_d;
  logic [AW:0]      rd_ptr_q,    rd_ptr_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [WIDTH-1:0] alu_a_q,     alu_a_d;
  logic [WIDTH-1:0] alu_b_q,     alu_b_d;
  logic [3:0]       alu_op_q,    alu_op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
`ifdef ALU_SEQ_FLAGS_EN
  logic [1:0]       rsp_flags_q, rsp_flags_d;
`endif

  cmd_t             mem_q [DEPTH];

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  cmd_t             head;
  cmd_t             push_entry;
  logic [WIDTH-1:0] issue_a;

  // ---------------------------------------------------------------------------
  // FIFO status. The extra MSB on each pointer counts wraps, so equal low bits
  // with differing MSBs means full and fully equal pointers means empty.
  // ---------------------------------------------------------------------------
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // cmd_ready looks only at registered occupancy: a pop on the same edge does
  // not free a slot for a push until the following cycle.
  assign push = bus.cmd_valid && !full;

  assign push_entry = '{op:  bus.cmd_op,
                        a:   bus.cmd_a,
                        b:   bus.cmd_b,
                        acc: bus.cmd_acc};

  // NOTE: storage has no reset; the pointers alone define which entries are
  // valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
    end
  end

  // Operand A selection uses the accumulator as it stands at the pop edge.
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign issue_a = head.acc ? acc_q : head.a;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: combinational logic uses blocking '=' so later statements see the
  // values just computed; the flops below use non-blocking '<=' so every
  // register samples the pre-edge values together.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    acc_d       = acc_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef ALU_SEQ_FLAGS_EN
    rsp_flags_d = rsp_flags_q;
`endif
    pop         = 1'b0;

    // Clear is applied first so the EXEC capture below overrides it.
    if (bus.acc_clr) begin
      acc_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          alu_a_d  = issue_a;
          alu_b_d  = head.b;
          alu_op_d = head.op;
          state_d  = S_EXEC;
        end
      end

      // The ALU has had a full cycle to settle on the registered operands.
      S_EXEC: begin
        rsp_data_d  = alu_s;
        acc_d       = alu_s;
        rsp_valid_d = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
        rsp_flags_d = {alu_s[WIDTH-1], (alu_s == '0)};
`endif
        state_d     = S_RESP;
      end

      // Response and ALU drive lines stay frozen until the consumer takes it.
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!empty) begin
            pop      = 1'b1;
            alu_a_d  = issue_a;
            alu_b_d  = head.b;
            alu_op_d = head.op;
            state_d  = S_EXEC;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers (FSM state, FIFO pointers, accumulator and all outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      acc_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      rsp_flags_q <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      acc_q       <= acc_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef ALU_SEQ_FLAGS_EN
      rsp_flags_q <= rsp_flags_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.cmd_ready = !full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign bus.rsp_flags = rsp_flags_q;
`endif
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign busy          = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Self-checking bench for alu_sequencer. A reference ALU closes the loop on
// alu_a/alu_b/alu_op -> alu_s. A scoreboard computes each expected result
// when a command is accepted and compares it when the response is taken.
// A vector table exercises single operations and an accumulator chain;
// hand-written sequences cover back-pressure, push-while-full and reset.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_s;
  logic             busy;

  alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op),
    .alu_s  (alu_s),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Reference ALU: Op[2] inverts B and supplies carry-in; Op[1:0] selects
  // AND, OR, ADD/SUB or the sign bit of the sum. Op[3] has no effect here.
  function automatic logic [WIDTH-1:0] alu_ref(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    bb  = op[2] ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, op[2]};
    case (op[1:0])
      2'b00:   r = a & bb;
      2'b01:   r = a | bb;
      2'b10:   r = sum[WIDTH-1:0];
      default: r = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
    endcase
    return r;
  endfunction

  always_comb alu_s = alu_ref(alu_op, alu_a, alu_b);

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int rsp_seen = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [1:0]       flags;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] model_acc = '0;
  exp_t             mon_e;
  logic [WIDTH-1:0] mon_a;
  logic [WIDTH-1:0] mon_s;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge while inputs are stable.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.acc_clr) model_acc = '0;
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_seen++;
        check("sb_has_expect", 32'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("sb_data", bus.rsp_data, mon_e.data);
`ifdef ALU_SEQ_FLAGS_EN
          check("sb_flags", bus.rsp_flags, mon_e.flags);
`endif
        end
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        mon_a      = bus.cmd_acc ? model_acc : bus.cmd_a;
        mon_s      = alu_ref(bus.cmd_op, mon_a, bus.cmd_b);
        model_acc  = mon_s;
        mon_e.data  = mon_s;
        mon_e.flags = {mon_s[WIDTH-1], (mon_s == '0)};
        sb_q.push_back(mon_e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks; each returns 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic acc);
    logic accepted;
    accepted      = 1'b0;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_acc   = acc;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    check("cmd_accept", accepted, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && !bus.rsp_valid) begin
        idle = 1'b1;
        break;
      end
    end
    check("reach_idle", idle, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    bus.acc_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.acc_clr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic             clr;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc;
    logic [WIDTH-1:0] exp;
    logic [1:0]       flags;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

  logic [WIDTH-1:0] prev;
  int               acc_n;
  int               hs_n;
  int               stamp[8];

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_acc   = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.rsp_ready = 1'b1;

    //           clr   op     a      b      acc   exp    {neg,zero}
    vecs[0]  = '{1'b0, 4'h2, 4'h3, 4'h4, 1'b0, 4'h7, 2'b00};
    vecs[1]  = '{1'b0, 4'h6, 4'h5, 4'h7, 1'b0, 4'hE, 2'b10};
    vecs[2]  = '{1'b0, 4'h0, 4'hC, 4'hA, 1'b0, 4'h8, 2'b10};
    vecs[3]  = '{1'b0, 4'h1, 4'hC, 4'h3, 1'b0, 4'hF, 2'b10};
    vecs[4]  = '{1'b0, 4'h7, 4'h3, 4'h5, 1'b0, 4'h1, 2'b00};
    vecs[5]  = '{1'b0, 4'hA, 4'h1, 4'h2, 1'b0, 4'h3, 2'b00};
    vecs[6]  = '{1'b0, 4'h4, 4'hF, 4'h5, 1'b0, 4'hA, 2'b10};
    vecs[7]  = '{1'b1, 4'h2, 4'h9, 4'h5, 1'b1, 4'h5, 2'b00};
    vecs[8]  = '{1'b0, 4'h2, 4'h0, 4'h5, 1'b1, 4'hA, 2'b10};
    vecs[9]  = '{1'b0, 4'h2, 4'h6, 4'h5, 1'b1, 4'hF, 2'b10};
    vecs[10] = '{1'b0, 4'h2, 4'h0, 4'h5, 1'b1, 4'h4, 2'b00};
    vecs[11] = '{1'b0, 4'h6, 4'h0, 4'h4, 1'b1, 4'h0, 2'b01};

    // ---- Reset state ----
    #2;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
`ifdef ALU_SEQ_FLAGS_EN
    check("rst_rsp_flags", bus.rsp_flags, 0);
`endif
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1);

    // ---- Table: single commands, latency, operand lines ----
    prev = '0;
    for (int v = 0; v < NVEC; v++) begin
      wait_idle();
      if (vecs[v].clr) begin
        pulse_clr();
        prev = '0;
      end
      send(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].acc);
      @(negedge clk);
      check("vec_busy", busy, 1);
      @(negedge clk);
      check("vec_lat_exec", bus.rsp_valid, 0);
      @(negedge clk);
      check("vec_lat_resp", bus.rsp_valid, 1);
      check("vec_data", bus.rsp_data, vecs[v].exp);
      check("vec_alu_op", alu_op, vecs[v].op);
      check("vec_alu_b", alu_b, vecs[v].b);
      check("vec_alu_a", alu_a, vecs[v].acc ? prev : vecs[v].a);
`ifdef ALU_SEQ_FLAGS_EN
      check("vec_flags", bus.rsp_flags, vecs[v].flags);
`endif
      prev = vecs[v].exp;
      @(negedge clk);
      check("vec_busy_done", busy, 0);
      check("vec_rsp_clear", bus.rsp_valid, 0);
      @(posedge clk);
      #1;
    end

    // ---- Back-pressure: 6 offered, 5 accepted, then push-while-full ----
    wait_idle();
    bus.rsp_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_op    = 4'h2;
      bus.cmd_a     = WIDTH'(i);
      bus.cmd_b     = 4'h3;
      bus.cmd_acc   = 1'b0;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      if (bus.cmd_ready) acc_n++;
      @(posedge clk);
      #1;
    end
    check("bp_accepted", acc_n, 5);
    @(negedge clk);
    check("bp_full_ready", bus.cmd_ready, 0);
    @(posedge clk);
    #1;
    // Release the response and offer a new command on the same cycle: the
    // FSM pops a full FIFO while the push must still be refused.
    bus.rsp_ready = 1'b1;
    bus.cmd_op    = 4'h1;
    bus.cmd_a     = 4'h8;
    bus.cmd_b     = 4'h1;
    hs_n = 0;
    for (int t = 0; t < 40 && hs_n < 5; t++) begin
      @(negedge clk);
      if (t == 0) check("pop_full_push_refused", bus.cmd_ready, 0);
      if (bus.rsp_valid && bus.rsp_ready) begin
        stamp[hs_n] = t;
        hs_n++;
      end
      if (t == 0) begin
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
      end
    end
    check("bp_rsp_count", hs_n, 5);
    for (int j = 1; j < 5; j++) check("bp_spacing", stamp[j] - stamp[j-1], 2);
    wait_idle();
    check("bp_sb_drained", sb_q.size(), 0);

    // ---- Reset while in EXEC with two commands queued ----
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'h2, WIDTH'(i + 1), 4'h1, 1'b0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rr_first_rsp", bus.rsp_valid, 1);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rr_rsp_valid", bus.rsp_valid, 0);
    check("rr_busy", busy, 0);
    check("rr_alu_a", alu_a, 0);
    check("rr_alu_b", alu_b, 0);
    check("rr_alu_op", alu_op, 0);
    check("rr_rsp_data", bus.rsp_data, 0);
    sb_q.delete();
    model_acc = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    check("rr_cmd_ready", bus.cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_no_stale", bus.rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    send(4'h1, 4'h5, 4'h2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    check("rr_new_cmd_done", sb_q.size(), 0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-side initiator that drives the 4-bit combinational ALU and collects its results.
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the ALU on registered A/B/Op lines, captures S, and returns it over a valid/ready response interface.
- Keeps an accumulator so that chained operations can use the previous result as operand A.

Parameters:
- WIDTH, 4, datapath width; matches the ALU operand and result width.
- DEPTH, 4, command FIFO entries; power of 2, ≥2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_op  input  4  ALU opcode. Op[2] inverts B and sets carry-in. Op[1:0]: 00 AND, 01 OR, 10 ADD/SUB, 11 sign of sum.
- cmd_a  input  WIDTH  operand A; ignored when cmd_acc=1.
- cmd_b  input  WIDTH  operand B.
- cmd_acc  input  1  use the accumulator as operand A.
- acc_clr  input  1  synchronous accumulator clear.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  WIDTH  captured ALU result.
- alu_a  output  WIDTH  to ALU A.
- alu_b  output  WIDTH  to ALU B.
- alu_op  output  4  to ALU Op.
- alu_s  input  WIDTH  from ALU S.
- busy  output  1  FSM not IDLE or FIFO not empty.

Behaviour:
- Reset (async, rst_n=0): all of the following clear immediately.
  - FIFO empty, pointers 0.
  - State IDLE.
  - acc=0.
  - alu_a, alu_b, alu_op, rsp_data = 0.
  - rsp_valid=0, busy=0.
  - cmd_ready=1 once rst_n=1.
  - An in-flight command is dropped and no response is produced.
- FIFO
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full.
  - Entry stores {op, a, b, acc}.
  - Pointers wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.
  - No bypass: a command pushed at edge k is poppable no earlier than edge k+1.
  - Push and pop may occur on the same edge; occupancy is unchanged.
  - Push is blocked while full, even if a pop occurs that edge.
- FSM
  - IDLE: if the FIFO is not empty, then at the edge:
    - pop;
    - load alu_op=op, alu_b=b, and alu_a = acc ? acc_reg : a;
    - go to EXEC.
  - EXEC (one cycle; the ALU settles combinationally): at the edge:
    - rsp_data <= alu_s;
    - acc <= alu_s;
    - rsp_valid <= 1;
    - go to RESP.
  - RESP: hold rsp_valid, rsp_data and alu_* stable until rsp_ready=1. On the handshake edge:
    - if the FIFO is not empty, pop the next command directly into EXEC (same load rules, rsp_valid <= 0);
    - otherwise go to IDLE, rsp_valid <= 0.
- Latency and throughput
  - A command accepted at edge k into an empty, idle block gives rsp_valid=1 after edge k+2.
  - Sustained throughput is one result per 2 cycles while rsp_ready=1.
- Accumulator
  - Operand selection uses the acc value at the pop edge.
  - A chain of acc commands therefore sees every prior result, because EXEC always precedes the next pop.
  - acc_clr sets acc=0 at the edge.
  - If acc_clr coincides with the EXEC capture edge, the capture wins.
- Arithmetic
  - The sequencer does not interpret results.
  - Results are modulo 2^WIDTH as produced by the ALU; carry-out is not observed.
  - Op[3] is forwarded unchanged.
- busy is registered-equivalent: (state != IDLE) || !empty.

Optional Feature:
- Macro ALU_SEQ_FLAGS_EN.
- Defined:
  - Adds output rsp_flags[1:0] = {neg, zero}.
  - Captured in EXEC alongside rsp_data: neg = alu_s[WIDTH-1], zero = (alu_s==0).
  - Reset value 2'b00; held with rsp_data.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Idle start, A=3, B=4, op=4'b0010, rsp_ready=1 -> rsp_valid after edge k+2 with rsp_data=7; busy then returns 0.
- SUB op=4'b0110, A=5, B=7 -> rsp_data=4'hE; with ALU_SEQ_FLAGS_EN, rsp_flags=2'b10. AND op=4'b0000, A=C, B=A -> 8. OR op=4'b0001, A=C, B=3 -> F.
- acc_clr, then four ADD commands with cmd_acc=1, B=5 -> responses 5, A, F, 4 (wrap-around); 4 gives rsp_flags=2'b00.
- rsp_ready=0, 6 back-to-back commands -> exactly 5 accepted (1 in RESP + DEPTH in FIFO), then cmd_ready=0. Releasing rsp_ready then returns all 5 results in order, 2 cycles apart.
- Push on the same edge that the FSM pops from a full FIFO -> push refused, with no loss or duplication.
- rst_n pulsed low while in EXEC with 2 commands queued -> rsp_valid=0, busy=0, alu_*=0 immediately. After release there are no stale responses and a new command completes normally.
